// File: rtl/chacha_pkg.sv
// Shared types and section geometry for the ChaCha keystream controller.
// Config byte addresses and section lengths used by the controller and its buffer.
package chacha_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_KEY,
        ST_WR_NNC,
        ST_WR_CTR,
        ST_WAIT,
        ST_READ,
        ST_STREAM
    } state_t;

    localparam int KEY_LEN  = 32;
    localparam int NNC_LEN  = 8;
    localparam int CTR_LEN  = 8;
    localparam int BLK_LEN  = 64;

    localparam int KEY_BASE = 0;
    localparam int NNC_BASE = 32;
    localparam int CTR_BASE = 40;
    localparam int CFG_END  = 48;

endpackage

// File: rtl/chacha_ks_buf.sv
// 64-byte keystream register file: one sequential write port, one indexed read port.
// A clear zeroes every byte so a stale block can never be streamed.
module chacha_ks_buf
    import chacha_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       we,
    input  logic [5:0] waddr,
    input  logic [7:0] wdata,
    input  logic [5:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem_q [BLK_LEN];
    logic [7:0] mem_d [BLK_LEN];

    always_comb begin
        mem_d = mem_q;
        if (clr) begin
            for (int i = 0; i < BLK_LEN; i++) begin
                mem_d[i] = 8'h00;
            end
        end else if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BLK_LEN; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/chacha_stream_ctrl.sv
// Controller that loads key/nonce/counter into a ChaCha core, reads 64-byte keystream
// blocks and XORs them onto a valid/ready plaintext byte stream.
module chacha_stream_ctrl
    import chacha_pkg::*;
#(
    parameter int MIN_CALC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_we,
    input  logic [5:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    input  logic       start,
    input  logic       stop,
    output logic       busy,
    output logic       ctr_wrap,
    input  logic       pt_valid,
    output logic       pt_ready,
    input  logic [7:0] pt_data,
    output logic       ct_valid,
    input  logic       ct_ready,
    output logic [7:0] ct_data,
    output logic       core_wr_key,
    output logic       core_wr_nnc,
    output logic       core_wr_ctr,
    output logic       core_hold,
    output logic       core_rd_blk,
    output logic [7:0] core_data_in,
    input  logic [7:0] core_data_out,
    input  logic       core_blk_ready
);

    localparam logic [5:0] KEY_LAST = 6'(KEY_LEN - 1);
    localparam logic [5:0] NNC_LAST = 6'(NNC_LEN - 1);
    localparam logic [5:0] CTR_LAST = 6'(CTR_LEN - 1);
    localparam logic [5:0] BLK_LAST = 6'(BLK_LEN - 1);
    localparam logic [5:0] MIN_WAIT = 6'(MIN_CALC);

    state_t       state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [5:0]   idx_q, idx_d;
    logic [255:0] key_q, key_d;
    logic [63:0]  nnc_q, nnc_d;
    logic [63:0]  ctr_q, ctr_d;
    logic         ctr_wrap_q, ctr_wrap_d;
    logic         ct_valid_q, ct_valid_d;
    logic [7:0]   ct_data_q, ct_data_d;

    logic         ks_we, ks_clr;
    logic [7:0]   ks_rdata;
    logic         pt_fire;
    logic [4:0]   key_off;
    logic [2:0]   nnc_off, ctr_off;

    chacha_ks_buf u_ks_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ks_clr),
        .we    (ks_we),
        .waddr (cnt_q),
        .wdata (core_data_out),
        .raddr (idx_q),
        .rdata (ks_rdata)
    );

    assign key_off = 5'(cfg_addr - 6'(KEY_BASE));
    assign nnc_off = 3'(cfg_addr - 6'(NNC_BASE));
    assign ctr_off = 3'(cfg_addr - 6'(CTR_BASE));
    assign pt_fire = pt_valid && pt_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            key_q      <= '0;
            nnc_q      <= '0;
            ctr_q      <= '0;
            ctr_wrap_q <= 1'b0;
            ct_valid_q <= 1'b0;
            ct_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            key_q      <= key_d;
            nnc_q      <= nnc_d;
            ctr_q      <= ctr_d;
            ctr_wrap_q <= ctr_wrap_d;
            ct_valid_q <= ct_valid_d;
            ct_data_q  <= ct_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        key_d      = key_q;
        nnc_d      = nnc_q;
        ctr_d      = ctr_q;
        ctr_wrap_d = ctr_wrap_q;
        ct_valid_d = ct_valid_q;
        ct_data_d  = ct_data_q;
        ks_we      = 1'b0;
        ks_clr     = 1'b0;

        // A pending ciphertext byte drains in every state.
        if (ct_valid_q && ct_ready) begin
            ct_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    if (cfg_addr < 6'(NNC_BASE)) begin
                        key_d[8*key_off +: 8] = cfg_wdata;
                    end else if (cfg_addr < 6'(CTR_BASE)) begin
                        nnc_d[8*nnc_off +: 8] = cfg_wdata;
                    end else if (cfg_addr < 6'(CFG_END)) begin
                        ctr_d[8*ctr_off +: 8] = cfg_wdata;
                    end
                end
                if (start && !stop) begin
                    state_d    = ST_WR_KEY;
                    cnt_d      = '0;
                    ctr_wrap_d = 1'b0;
                end
            end
            ST_WR_KEY: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == KEY_LAST) begin
                    state_d = ST_WR_NNC;
                    cnt_d   = '0;
                end
            end
            ST_WR_NNC: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == NNC_LAST) begin
                    state_d = ST_WR_CTR;
                    cnt_d   = '0;
                end
            end
            ST_WR_CTR: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == CTR_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                // cnt_q saturates at MIN_WAIT; only then is blk_ready trusted.
                if (cnt_q >= MIN_WAIT) begin
                    if (core_blk_ready) begin
                        state_d = ST_READ;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_READ: begin
                ks_we = 1'b1;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == BLK_LAST) begin
                    state_d = ST_STREAM;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_STREAM: begin
                if (pt_fire) begin
                    ct_data_d  = pt_data ^ ks_rdata;
                    ct_valid_d = 1'b1;
                    idx_d      = idx_q + 6'd1;
                    if (idx_q == BLK_LAST) begin
                        ctr_d   = ctr_q + 64'd1;
                        state_d = ST_WR_CTR;
                        cnt_d   = '0;
                        idx_d   = '0;
                        if (&ctr_q) begin
                            ctr_wrap_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything; the counter keeps its pre-abort value.
        if (stop && state_q != ST_IDLE) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            idx_d      = '0;
            ctr_d      = ctr_q;
            ctr_wrap_d = ctr_wrap_q;
            ct_valid_d = 1'b0;
            ct_data_d  = ct_data_q;
            ks_we      = 1'b0;
            ks_clr     = 1'b1;
        end
    end

    always_comb begin
        busy         = (state_q != ST_IDLE);
        core_hold    = 1'b0;
        core_wr_key  = 1'b0;
        core_wr_nnc  = 1'b0;
        core_wr_ctr  = 1'b0;
        core_rd_blk  = 1'b0;
        core_data_in = '0;
        pt_ready     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                core_hold = 1'b1;
            end
            ST_WR_KEY: begin
                core_wr_key  = (cnt_q == 6'd0);
                core_data_in = key_q[8*cnt_q[4:0] +: 8];
            end
            ST_WR_NNC: begin
                core_wr_nnc  = (cnt_q == 6'd0);
                core_data_in = nnc_q[8*cnt_q[2:0] +: 8];
            end
            ST_WR_CTR: begin
                core_wr_ctr  = (cnt_q == 6'd0);
                core_data_in = ctr_q[8*cnt_q[2:0] +: 8];
            end
            ST_READ: begin
                core_rd_blk = (cnt_q == 6'd0);
            end
            ST_STREAM: begin
                pt_ready = !ct_valid_q || ct_ready;
            end
            default: begin
            end
        endcase
    end

    assign ctr_wrap = ctr_wrap_q;
    assign ct_valid = ct_valid_q;
    assign ct_data  = ct_data_q;

endmodule
